// File: rtl/vram_arbiter_if.sv
// Bundles the CPU write channel, VGA read channel and VRAM bus seen by vram_arbiter.
// The slave modport is the arbiter's view; master is the CPU/VGA/VRAM side.
interface vram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 12
);
  logic              CPU_WR_VALID;
  logic              CPU_WR_READY;
  logic [ADDR_W-1:0] CPU_WR_ADDR;
  logic [DATA_W-1:0] CPU_WR_DATA;
  logic              VGA_RD_REQ;
  logic [ADDR_W-1:0] VGA_RD_ADDR;
  logic              VGA_RD_VALID;
  logic [DATA_W-1:0] VGA_RD_DATA;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [DATA_W-1:0] RAM_WDATA;
  logic              RAM_WE;
  logic [DATA_W-1:0] RAM_RDATA;

  modport slave (
    input  CPU_WR_VALID, CPU_WR_ADDR, CPU_WR_DATA, VGA_RD_REQ, VGA_RD_ADDR, RAM_RDATA,
    output CPU_WR_READY, VGA_RD_VALID, VGA_RD_DATA, RAM_ADDR, RAM_WDATA, RAM_WE
  );

  modport master (
    output CPU_WR_VALID, CPU_WR_ADDR, CPU_WR_DATA, VGA_RD_REQ, VGA_RD_ADDR, RAM_RDATA,
    input  CPU_WR_READY, VGA_RD_VALID, VGA_RD_DATA, RAM_ADDR, RAM_WDATA, RAM_WE
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA reads always win, CPU writes are buffered and drained into idle slots.
// Optional macro VRAM_ARB_STATS_EN adds STALL_CNT, a saturating count of back-pressured CPU cycles.
module vram_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        CLK1_50,
  input  logic                        RST_N,
  vram_arbiter_if.slave               bus,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]                 STALL_CNT
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_ready;
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]  r_level, w_level_nxt;
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic              w_empty, w_push, w_pop;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_rd_vld_p0, r_rd_vld_p1, r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  assign w_empty = (r_level == '0);
  // READY comes from registered state only, so a full FIFO refuses a push even while popping.
  assign w_push  = bus.CPU_WR_VALID & r_ready;
  assign w_pop   = (w_state_nxt == S_WRITE);

  always_comb begin
    w_state_nxt = S_IDLE;
    if (bus.VGA_RD_REQ) w_state_nxt = S_READ;
    else if (!w_empty)  w_state_nxt = S_WRITE;
  end

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + LVL_W'(1);
    else if (!w_push && w_pop) w_level_nxt = r_level - LVL_W'(1);
  end

  always_ff @(posedge CLK1_50 or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK1_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != LVL_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge CLK1_50) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= bus.CPU_WR_ADDR;
      r_fifo_data[r_wr_ptr] <= bus.CPU_WR_DATA;
    end
  end

  // RAM command register: address and data hold through IDLE cycles.
  always_ff @(posedge CLK1_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      case (w_state_nxt)
        S_READ:  r_ram_addr <= bus.VGA_RD_ADDR;
        S_WRITE: begin
          r_ram_addr  <= r_fifo_addr[r_rd_ptr];
          r_ram_wdata <= r_fifo_data[r_rd_ptr];
        end
        default: ;
      endcase
    end
  end

  // p0: address issued; p1: RAM data present; then register data and valid.
  always_ff @(posedge CLK1_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_vld_p0 <= 1'b0;
      r_rd_vld_p1 <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_rd_vld_p0 <= (w_state_nxt == S_READ);
      r_rd_vld_p1 <= r_rd_vld_p0;
      r_rd_valid  <= r_rd_vld_p1;
      if (r_rd_vld_p1) r_rd_data <= bus.RAM_RDATA;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge CLK1_50 or negedge RST_N) begin
    if (!RST_N) r_stall_cnt <= '0;
    else if (bus.CPU_WR_VALID && !r_ready && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign STALL_CNT = r_stall_cnt;
`endif

  assign bus.CPU_WR_READY = r_ready;
  assign bus.RAM_ADDR     = r_ram_addr;
  assign bus.RAM_WDATA    = r_ram_wdata;
  assign bus.RAM_WE       = (r_state == S_WRITE);
  assign bus.VGA_RD_VALID = r_rd_valid;
  assign bus.VGA_RD_DATA  = r_rd_data;
  assign FIFO_LEVEL       = r_level;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized and directed bench for vram_arbiter against a transaction-level reference model.
module tb_vram_arbiter;
  localparam int AW    = 13;
  localparam int DW    = 12;
  localparam int DEPTH = 4;

  logic CLK1_50 = 1'b0;
  logic RST_N;
  logic [$clog2(DEPTH):0] FIFO_LEVEL;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] STALL_CNT;
`endif

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .CLK1_50   (CLK1_50),
    .RST_N     (RST_N),
    .bus       (bus),
    .FIFO_LEVEL(FIFO_LEVEL)
`ifdef VRAM_ARB_STATS_EN
    ,
    .STALL_CNT (STALL_CNT)
`endif
  );

  always #5 CLK1_50 = ~CLK1_50;

  // Environment VRAM: registered read, one-cycle latency, preloaded with addr+0x100.
  logic [DW-1:0] vram [8192];
  initial for (int i = 0; i < 8192; i++) vram[i] = DW'(i + 'h100);
  always @(posedge CLK1_50) begin
    if (bus.RAM_WE) vram[bus.RAM_ADDR] <= bus.RAM_WDATA;
    bus.RAM_RDATA <= vram[bus.RAM_ADDR];
  end

  // Reference model state
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int due; logic [DW-1:0] d; } rd_t;
  wr_t           m_fifo [$];
  rd_t           m_rdq  [$];
  logic [DW-1:0] m_ref  [8192];
  logic          m_ready, m_we, m_valid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd_data;
  logic [15:0]   m_stall;
  int            m_cyc;
  int            n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_rdq.delete();
    m_ready = 0; m_we = 0; m_valid = 0;
    m_addr = '0; m_wdata = '0; m_rd_data = '0; m_stall = '0;
  endtask

  // Applies the arbitration rules for one rising edge using the inputs currently driven.
  task automatic model_step();
    wr_t e;
    rd_t r;
    bit  push;
    push = bus.CPU_WR_VALID && m_ready;
    if (bus.CPU_WR_VALID && !m_ready && m_stall != 16'hFFFF) m_stall++;
    m_cyc++;
    if (bus.VGA_RD_REQ) begin
      r.due = m_cyc + 2;
      r.d   = m_ref[bus.VGA_RD_ADDR];
      m_rdq.push_back(r);
      m_addr = bus.VGA_RD_ADDR;
      m_we   = 0;
    end else if (m_fifo.size() > 0) begin
      e = m_fifo.pop_front();
      m_addr  = e.a;
      m_wdata = e.d;
      m_we    = 1;
      m_ref[e.a] = e.d;
    end else begin
      m_we = 0;
    end
    if (push) begin
      e.a = bus.CPU_WR_ADDR;
      e.d = bus.CPU_WR_DATA;
      m_fifo.push_back(e);
    end
    m_ready = (m_fifo.size() != DEPTH);
    m_valid = 0;
    if (m_rdq.size() > 0 && m_rdq[0].due == m_cyc) begin
      r = m_rdq.pop_front();
      m_valid   = 1;
      m_rd_data = r.d;
    end
  endtask

  task automatic check_all();
    chk("ready",     32'(bus.CPU_WR_READY), 32'(m_ready));
    chk("level",     32'(FIFO_LEVEL),       32'(m_fifo.size()));
    chk("ram_we",    32'(bus.RAM_WE),       32'(m_we));
    chk("ram_addr",  32'(bus.RAM_ADDR),     32'(m_addr));
    chk("ram_wdata", 32'(bus.RAM_WDATA),    32'(m_wdata));
    chk("rd_valid",  32'(bus.VGA_RD_VALID), 32'(m_valid));
    chk("rd_data",   32'(bus.VGA_RD_DATA),  32'(m_rd_data));
`ifdef VRAM_ARB_STATS_EN
    chk("stall_cnt", 32'(STALL_CNT),        32'(m_stall));
`endif
  endtask

  task automatic cycle();
    @(posedge CLK1_50);
    if (RST_N) model_step();
    else       model_reset();
    @(negedge CLK1_50);
    check_all();
  endtask

  task automatic drive(input bit v, input int wa, input int wd, input bit rq, input int ra);
    bus.CPU_WR_VALID = v;
    bus.CPU_WR_ADDR  = AW'(wa);
    bus.CPU_WR_DATA  = DW'(wd);
    bus.VGA_RD_REQ   = rq;
    bus.VGA_RD_ADDR  = AW'(ra);
    cycle();
  endtask

  // Called at a falling edge: asynchronous assert, one held edge, release.
  task automatic pulse_reset();
    bus.CPU_WR_VALID = 0;
    bus.VGA_RD_REQ   = 0;
    RST_N = 0;
    #1;
    model_reset();
    check_all();
    cycle();
    RST_N = 1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; m_cyc = 0;
    for (int i = 0; i < 8192; i++) m_ref[i] = DW'(i + 'h100);
    model_reset();
    RST_N = 0;
    bus.CPU_WR_VALID = 0; bus.CPU_WR_ADDR = '0; bus.CPU_WR_DATA = '0;
    bus.VGA_RD_REQ = 0;   bus.VGA_RD_ADDR = '0;
    repeat (2) cycle();
    RST_N = 1;
    drive(0, 0, 0, 0, 0);

    // single write
    drive(1, 'h0010, 'hF00, 0, 0);
    repeat (4) drive(0, 0, 0, 0, 0);

    // three back-to-back reads
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, i);
    repeat (4) drive(0, 0, 0, 0, 0);

    // starvation under continuous reads, then in-order drain
    for (int i = 0; i < 10; i++) drive(1, 'h40 + i, 'h500 + i, 1, i);
    repeat (7) drive(0, 0, 0, 0, 0);

    // write and read of the same address in one cycle: no forwarding
    drive(1, 'h0020, 'hABC, 1, 'h0020);
    repeat (5) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 'h0020);
    repeat (4) drive(0, 0, 0, 0, 0);

    // reset one cycle after a read, with writes queued behind it
    for (int i = 0; i < 3; i++) drive(1, 'h30 + i, 'h7A0 + i, 1, 'h30);
    drive(0, 0, 0, 1, 5);
    pulse_reset();
    repeat (5) drive(0, 0, 0, 0, 0);

    // randomized traffic with occasional reset pulses
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(199) == 0) pulse_reset();
      else drive($urandom_range(99) < 60, $urandom_range(15), $urandom_range(4095),
                 $urandom_range(99) < 40, $urandom_range(15));
    end
    repeat (8) drive(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video RAM arbiter between the CPU's pixel-write path and the VGA scan-out read path. VGA reads always win and complete with a fixed latency, so scan-out never tears. CPU writes are buffered in a small FIFO and drained into free RAM cycles. Sits between the CPU core, the VGA timing generator and the VRAM block, all on the 50 MHz board clock.

## Interface
- ADDR_W, 13, VRAM word address width
- DATA_W, 12, pixel width (4b R, 4b G, 4b B)
- FIFO_DEPTH, 4, CPU write FIFO entries; must be a power of two, at least 2
- Clock and reset: one clock, `CLK1_50`. Reset is `RST_N`, asynchronous and active-low.
- CLK1_50  in  1  system clock; all state updates on the rising edge
- RST_N  in  1  asynchronous active-low reset
- CPU_WR_VALID  in  1  CPU write request
- CPU_WR_READY  out  1  FIFO can accept; transfer occurs when VALID & READY
- CPU_WR_ADDR  in  ADDR_W  write address
- CPU_WR_DATA  in  DATA_W  write pixel
- VGA_RD_REQ  in  1  single-cycle read request, at most one per cycle
- VGA_RD_ADDR  in  ADDR_W  read address
- VGA_RD_VALID  out  1  read data valid pulse
- VGA_RD_DATA  out  DATA_W  read pixel; holds its value between pulses
- RAM_ADDR  out  ADDR_W  registered VRAM address
- RAM_WDATA  out  DATA_W  registered VRAM write data
- RAM_WE  out  1  registered VRAM write enable
- RAM_RDATA  in  DATA_W  VRAM read data, valid 1 cycle after RAM_ADDR
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- The FSM state is the RAM op issued this cycle: IDLE, READ or WRITE. It is re-evaluated every cycle:
  - VGA_RD_REQ=1 → READ. RAM_ADDR=VGA_RD_ADDR, RAM_WE=0.
  - Otherwise, FIFO non-empty → WRITE. Pop the head; RAM_ADDR/RAM_WDATA take the head; RAM_WE=1.
  - Otherwise → IDLE. RAM_WE=0; RAM_ADDR and RAM_WDATA hold their values.
- Strict VGA priority. CPU writes can starve for as long as VGA_RD_REQ stays high; the FIFO then fills and CPU_WR_READY drops.
- CPU_WR_READY = !full. It is registered-state based and independent of whether a pop happens this cycle.
  - When full, no push is taken, even in a cycle that pops.
  - Push and pop in the same cycle are allowed when not full; the level is unchanged.
- FIFO order is strict; writes reach RAM in acceptance order.
- No forwarding. A VGA read of an address with a write still in the FIFO returns the old RAM contents.
- A read pipeline shift register (2 bits) tracks outstanding READs and produces VGA_RD_VALID.
- Reset (RST_N=0, any time, including mid-read or mid-drain):
  - State=IDLE, FIFO emptied, read pipeline cleared.
  - RAM_WE=0, RAM_ADDR=0, RAM_WDATA=0.
  - VGA_RD_VALID=0, VGA_RD_DATA=0, FIFO_LEVEL=0, CPU_WR_READY=0.
  - CPU_WR_READY goes to 1 on the first clock edge after release.
  - Reads in flight at reset are discarded and never produce a VALID.

## Timing
- VGA read:
  - REQ sampled at edge t.
  - RAM_ADDR valid after edge t.
  - RAM_RDATA valid after edge t+1.
  - VGA_RD_DATA registered and VGA_RD_VALID=1 after edge t+2.
  - Fixed latency of 3 cycles from REQ to VALID. Back-to-back REQs give back-to-back VALIDs.
- CPU write:
  - Accepted at edge t.
  - Visible in FIFO_LEVEL after edge t.
  - Earliest RAM_WE=1 is after edge t+1, provided VGA_RD_REQ=0 in that cycle.
- FIFO_LEVEL and CPU_WR_READY update on the same edge as the push or pop.

## Configuration
- `VRAM_ARB_STATS_EN`, when defined, adds output STALL_CNT (16 bits).
  - Counts cycles with CPU_WR_VALID=1 && CPU_WR_READY=0.
  - Saturates at 16'hFFFF.
  - Reset to 0 by RST_N.
- When not defined, the port and counter are absent and there is no other behavioural difference.

## Test plan
- Reset release, idle inputs → after 1 edge: CPU_WR_READY=1, FIFO_LEVEL=0, RAM_WE=0. Assert RST_N=0 mid-stream → all outputs 0 asynchronously.
- One CPU write, addr 13'h0010, data 12'hF00, no VGA traffic → RAM_WE=1 for exactly 1 cycle, 2 cycles after acceptance, with RAM_ADDR=13'h0010 and RAM_WDATA=12'hF00; FIFO_LEVEL returns to 0.
- VGA REQ on 3 consecutive cycles, addrs 0, 1, 2, RAM model returning addr+12'h100 → VALID high for 3 consecutive cycles starting 3 cycles after the first REQ, data 12'h100, 12'h101, 12'h102.
- VGA_RD_REQ held high for 10 cycles while the CPU writes continuously → READY drops after 4 accepts, no RAM_WE during REQ. After REQ falls, 4 writes drain on consecutive cycles in order. Under `VRAM_ARB_STATS_EN`, STALL_CNT equals the number of VALID&!READY cycles.
- Write to 13'h0020 accepted while REQ reads 13'h0020 in the same cycle → VGA gets the old value; RAM is written the cycle after REQ deasserts.
- RST_N pulsed low one cycle after a VGA REQ → no VGA_RD_VALID is ever produced for that request; FIFO contents are lost and FIFO_LEVEL=0.
